// File: rtl/fetch_stage0.sv
// fetch_stage0: BPF pipeline stage 0. Owns the PC, reads the 1-cycle instruction
// memory, and hands a registered instruction (with a one-entry skid) to stage 1.
//
// Ports:
//   clk, rst (async, active-low)   start           : launch a run at PC 0 (IDLE only)
//   inst_rd_en/addr/data           : instruction memory read port (data one cycle later)
//   stage1_stalled                 : stage 1 cannot take a new instruction this cycle
//   branch_valid/target            : resolved jump target from stage 2
//   opcode/jt/jf/k/imm_lsb_is_zero : registered instruction fields
//   PC_out, valid_out, busy        : source PC, output-live flag, state != IDLE
module fetch_stage0 #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       inst_rd_en,
    output logic [CODE_ADDR_WIDTH-1:0] inst_rd_addr,
    input  logic [63:0]                inst_rd_data,
    input  logic                       stage1_stalled,
    input  logic                       branch_valid,
    input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
    output logic [15:0]                opcode,
    output logic [7:0]                 jt,
    output logic [7:0]                 jf,
    output logic [31:0]                k,
    output logic                       imm_lsb_is_zero,
    output logic [CODE_ADDR_WIDTH-1:0] PC_out,
    output logic                       valid_out,
    output logic                       busy
);

    localparam int AW = CODE_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_BRANCH
    } state_t;

    typedef struct packed {
        logic [15:0]   opcode;
        logic [7:0]    jt;
        logic [7:0]    jf;
        logic [31:0]   k;
        logic [AW-1:0] pc;
    } inst_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc, pc_nx;
    logic [AW-1:0] pend_pc;
    logic          pending;
    logic          skid_valid;
    inst_t         skid;
    inst_t         arr;
    inst_t         out_q;
    logic          lsbz_q;
    logic          arr_jmp;
    logic          arr_ret;

    // The word on the bus belongs to the address issued last cycle.
    assign arr     = {inst_rd_data, pend_pc};
    assign arr_jmp = pending && (arr.opcode[2:0] == 3'b101);
    assign arr_ret = pending && (arr.opcode[2:0] == 3'b110);

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        // Holding off issue while a JMP/RET lands keeps at most one word in
        // flight, so the single skid entry can never overflow.
        inst_rd_en = (state == RUN) && !stage1_stalled && !skid_valid
                     && !arr_jmp && !arr_ret;
        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_nx    = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (arr_jmp) begin
                    state_nx = WAIT_BRANCH;
                end else if (arr_ret) begin
                    state_nx = IDLE;
                end else if (inst_rd_en) begin
                    pc_nx = pc + AW'(1);
                end
            end
            WAIT_BRANCH: begin
                if (branch_valid) begin
                    pc_nx    = branch_target;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            pend_pc    <= '0;
            pending    <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
            out_q      <= '0;
            valid_out  <= 1'b0;
            lsbz_q     <= 1'b1;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            pending <= inst_rd_en;
            pend_pc <= pc;
            if (!stage1_stalled) begin
                if (skid_valid) begin
                    out_q      <= skid;
                    lsbz_q     <= ~skid.k[0];
                    valid_out  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (pending) begin
                    out_q     <= arr;
                    lsbz_q    <= ~arr.k[0];
                    valid_out <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end else if (pending) begin
                skid       <= arr;
                skid_valid <= 1'b1;
            end
        end
    end

    assign inst_rd_addr    = pc;
    assign opcode          = out_q.opcode;
    assign jt              = out_q.jt;
    assign jf              = out_q.jf;
    assign k               = out_q.k;
    assign PC_out          = out_q.pc;
    assign imm_lsb_is_zero = lsbz_q;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_fetch_stage0.sv
// tb_fetch_stage0: self-checking bench for fetch_stage0 with a 1-cycle
// instruction memory model, directed sequences and a randomized program run.
module tb_fetch_stage0;

    localparam int AW = 10;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stall, bv;
    logic [AW-1:0] bt;
    logic          en;
    logic [AW-1:0] addr;
    logic [63:0]   rdata;
    logic [15:0]   op;
    logic [7:0]    jt, jf;
    logic [31:0]   k;
    logic          lsbz, vo, busy;
    logic [AW-1:0] pco;

    logic          start2, en2, lsbz2, vo2, busy2;
    logic [1:0]    addr2, pco2;
    logic [63:0]   rdata2;
    logic [15:0]   op2;
    logic [7:0]    jt2, jf2;
    logic [31:0]   k2;

    logic [63:0]   mem  [0:1023];
    logic [63:0]   mem2 [0:3];

    // Synchronous-read memories; the bus holds its last word when idle.
    always @(posedge clk) if (en) rdata <= mem[addr];
    always @(posedge clk) if (en2) rdata2 <= mem2[addr2];

    fetch_stage0 #(.CODE_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .inst_rd_en(en), .inst_rd_addr(addr), .inst_rd_data(rdata),
        .stage1_stalled(stall), .branch_valid(bv), .branch_target(bt),
        .opcode(op), .jt(jt), .jf(jf), .k(k), .imm_lsb_is_zero(lsbz),
        .PC_out(pco), .valid_out(vo), .busy(busy)
    );

    fetch_stage0 #(.CODE_ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .inst_rd_en(en2), .inst_rd_addr(addr2), .inst_rd_data(rdata2),
        .stage1_stalled(1'b0), .branch_valid(1'b0), .branch_target(2'b00),
        .opcode(op2), .jt(jt2), .jf(jf2), .k(k2), .imm_lsb_is_zero(lsbz2),
        .PC_out(pco2), .valid_out(vo2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int cons[$];
    int cons2[$];

    typedef struct {
        bit            start;
        bit            en;
        logic [AW-1:0] addr;
        bit            vo;
        logic [AW-1:0] pco;
        logic [15:0]   op;
        bit            lsbz;
        bit            busy;
    } vec_t;

    vec_t tv[7];

    function automatic logic [63:0] w(logic [15:0] o, logic [7:0] a,
                                      logic [7:0] b, logic [31:0] kk);
        return {o, a, b, kk};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_seq(string nm, int got[$], int exp[$]);
        bit ok;
        ok = (got.size() == exp.size());
        if (ok)
            foreach (exp[i]) if (got[i] != exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %p want %p", nm, got, exp);
        end
    endtask

    // One cycle: record what stage 1 accepts, then move to the next negedge.
    task automatic cyc();
        #2;
        if (vo && !stall) cons.push_back(int'(pco));
        if (vo2) cons2.push_back(int'(pco2));
        @(negedge clk);
    endtask

    task automatic do_reset();
        start  = 0;
        start2 = 0;
        stall  = 0;
        bv     = 0;
        rst    = 0;
        #1;
        rst    = 1;
        cyc();
        cons.delete();
        cons2.delete();
    endtask

    task automatic start_run();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic run_until_idle(string nm);
        int n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        cyc();
        chk(nm, busy, 0);
    endtask

    logic [2:0]    lows [6];
    logic [AW-1:0] tq[$];

    initial begin
        int exp_q[$];
        int n;
        rst    = 0;
        start  = 0;
        start2 = 0;
        stall  = 0;
        bv     = 0;
        bt     = '0;
        lows   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem2[i] = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", {en, vo, busy, pco, op, jt, jf, k, lsbz},
            {1'b0, 1'b0, 1'b0, 10'd0, 16'd0, 8'd0, 8'd0, 32'd0, 1'b1});
        chk("reset_state_w2", {en2, vo2, busy2, pco2, lsbz2},
            {1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
        rst = 1;
        @(negedge clk);

        // Table: three-instruction program ending in RET
        mem[0] = w(16'h0000, 8'd0, 8'd0, 32'd2);
        mem[1] = w(16'h0004, 8'd0, 8'd0, 32'd4);
        mem[2] = w(16'h0006, 8'd0, 8'd0, 32'd1);
        tv[0] = '{1, 0, 10'd0, 0, 10'd0, 16'h0, 1, 0};
        tv[1] = '{0, 1, 10'd0, 0, 10'd0, 16'h0, 1, 1};
        tv[2] = '{0, 1, 10'd1, 0, 10'd0, 16'h0, 1, 1};
        tv[3] = '{0, 1, 10'd2, 1, 10'd0, 16'h0, 1, 1};
        tv[4] = '{0, 0, 10'd3, 1, 10'd1, 16'h4, 1, 1};
        tv[5] = '{0, 0, 10'd3, 1, 10'd2, 16'h6, 0, 0};
        tv[6] = '{0, 0, 10'd3, 0, 10'd2, 16'h6, 0, 0};
        for (int i = 0; i < 7; i++) begin
            start = tv[i].start;
            #1;
            chk($sformatf("tbl%0d", i),
                {en, addr, vo, pco, op, lsbz, busy},
                {tv[i].en, tv[i].addr, tv[i].vo, tv[i].pco,
                 tv[i].op, tv[i].lsbz, tv[i].busy});
            @(negedge clk);
        end

        // Reset mid-run with PC 1 in flight
        do_reset();
        mem[0] = w(16'h0010, 8'd0, 8'd0, 32'h10);
        mem[1] = w(16'h0070, 8'd1, 8'd2, 32'h1234);
        mem[2] = w(16'h0006, 8'd0, 8'd0, 32'h0);
        start_run();
        cyc();
        rst = 0;
        #1;
        chk("rst_async", {vo, en, busy}, 3'b000);
        rst = 1;
        cyc();
        chk("rst_next", {vo, en, busy}, 3'b000);
        cons.delete();
        cyc();
        start_run();
        run_until_idle("rst_rerun_idle");
        exp_q = '{0, 1, 2};
        chk_seq("rst_rerun_seq", cons, exp_q);

        // Three-cycle stall with PC 4 in flight
        do_reset();
        for (int i = 0; i < 9; i++)
            mem[i] = w(16'(i << 4), 8'(i), 8'(i + 1), 32'(i));
        mem[9] = w(16'h0006, 8'd0, 8'd0, 32'd0);
        start_run();
        n = 0;
        while (!(en && addr == 10'd4) && n < 20) begin
            cyc();
            n++;
        end
        chk("stall_find_pc4", {en, addr}, {1'b1, 10'd4});
        cyc();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_hold%0d", i), {vo, pco, en},
                {1'b1, 10'd3, 1'b0});
            cyc();
        end
        stall = 0;
        #1;
        chk("stall_rel0", {vo, pco}, {1'b1, 10'd3});
        cyc();
        chk("stall_rel1", {vo, pco}, {1'b1, 10'd4});
        cyc();
        chk("stall_bubble", vo, 1'b0);
        cyc();
        chk("stall_rel3", {vo, pco}, {1'b1, 10'd5});
        run_until_idle("stall_idle");
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        chk_seq("stall_seq", cons, exp_q);

        // JMP at PC 2, branch to 9 four cycles after arrival
        do_reset();
        mem[0] = w(16'h0010, 8'd0, 8'd0, 32'd0);
        mem[1] = w(16'h0020, 8'd0, 8'd0, 32'd0);
        mem[2] = w(16'h0005, 8'd3, 8'd4, 32'd0);
        for (int i = 3; i < 9; i++) mem[i] = w(16'h0770, 8'd0, 8'd0, 32'd0);
        mem[9]  = w(16'h0004, 8'd0, 8'd0, 32'd8);
        mem[10] = w(16'h0006, 8'd0, 8'd0, 32'd0);
        start_run();
        n = 0;
        while (!(vo && pco == 10'd2) && n < 20) begin
            cyc();
            n++;
        end
        chk("jmp_seen", {vo, pco, op}, {1'b1, 10'd2, 16'h0005});
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("jmp_noread%0d", i), {en, busy}, 2'b01);
            cyc();
        end
        bv = 1;
        bt = 10'd9;
        #1;
        chk("jmp_br_cycle", en, 1'b0);
        cyc();
        bv = 0;
        #1;
        chk("jmp_target_issue", {en, addr}, {1'b1, 10'd9});
        run_until_idle("jmp_idle");
        exp_q = '{0, 1, 2, 9, 10};
        chk_seq("jmp_seq", cons, exp_q);

        // Stray branch_valid and start during RUN
        do_reset();
        for (int i = 0; i < 7; i++) mem[i] = w(16'(i << 4), 8'd0, 8'd0, 32'd0);
        mem[7] = w(16'h0006, 8'd0, 8'd0, 32'd0);
        start_run();
        cyc();
        cyc();
        bv = 1;
        bt = 10'd5;
        cyc();
        bv = 0;
        cyc();
        start = 1;
        cyc();
        start = 0;
        run_until_idle("ignore_idle");
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_seq("ignore_seq", cons, exp_q);

        // Two-bit PC wraps without RET
        do_reset();
        for (int i = 0; i < 4; i++) mem2[i] = w(16'(i << 4), 8'd0, 8'd0, 32'd0);
        start2 = 1;
        cyc();
        start2 = 0;
        n = 0;
        while (cons2.size() < 6 && n < 30) begin
            cyc();
            n++;
        end
        while (cons2.size() > 6) void'(cons2.pop_back());
        exp_q = '{0, 1, 2, 3, 0, 1};
        chk_seq("wrap_w2_seq", cons2, exp_q);

        // Randomized programs against a program-walk reference
        for (int run = 0; run < 6; run++) begin
            logic [AW-1:0] exp_pc;
            logic [63:0]   wd;
            bit            jmp_pend, need_br, done;
            int            dly;
            do_reset();
            for (int i = 0; i < 1024; i++) begin
                logic [31:0] r0, r1, r2;
                int          r;
                logic [2:0]  lo;
                r  = $urandom_range(0, 31);
                r0 = $urandom;
                r1 = $urandom;
                r2 = $urandom;
                if (r < 3)       lo = 3'd5;
                else if (r == 3) lo = 3'd6;
                else             lo = lows[r % 6];
                mem[i] = {r0[15:3], lo, r1[15:0], r2};
            end
            exp_pc   = '0;
            jmp_pend = 0;
            need_br  = 0;
            done     = 0;
            dly      = 0;
            tq.delete();
            start_run();
            n = 0;
            while (!done && n < 3000) begin
                stall = ($urandom_range(0, 2) == 0);
                bv    = 0;
                if (need_br) begin
                    if (dly == 0) begin
                        bv      = 1;
                        bt      = AW'($urandom);
                        tq.push_back(bt);
                        need_br = 0;
                    end else begin
                        dly--;
                    end
                end
                #2;
                if (vo && !stall) begin
                    if (jmp_pend) begin
                        chk("rand_br_order", tq.size() > 0, 1'b1);
                        if (tq.size() > 0) exp_pc = tq.pop_front();
                        jmp_pend = 0;
                    end
                    wd = mem[exp_pc];
                    chk($sformatf("rand%0d_pc%0d", run, exp_pc),
                        {pco, op, jt, jf, k, lsbz},
                        {exp_pc, wd, ~wd[0]});
                    if (wd[50:48] == 3'b101) begin
                        jmp_pend = 1;
                        need_br  = 1;
                        dly      = $urandom_range(0, 4);
                    end else if (wd[50:48] == 3'b110) begin
                        done = 1;
                    end else begin
                        exp_pc = exp_pc + AW'(1);
                    end
                end
                @(negedge clk);
                n++;
            end
            chk($sformatf("rand%0d_ret", run), done, 1'b1);
            bv = 0;
            for (int i = 0; i < 3; i++) begin
                stall = ($urandom_range(0, 1) == 0);
                #1;
                chk($sformatf("rand%0d_tail%0d", run, i),
                    {busy, en, vo}, 3'b000);
                @(negedge clk);
            end
            stall = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
